// File: rtl/muldiv_pkg.sv
// Shared types and opcodes for the iterative multiply/divide engine and the HI/LO stage.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam logic [3:0] F_MFHI = 4'b0000;
  localparam logic [3:0] F_MTHI = 4'b0001;
  localparam logic [3:0] F_MFLO = 4'b0010;
  localparam logic [3:0] F_MTLO = 4'b0011;
  localparam logic [3:0] F_MULT = 4'b1000;
  localparam logic [3:0] F_DIV  = 4'b1010;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module muldiv_iter_step #(
  parameter int N = 3
) (
  input  logic         i_div,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [N:0]   i_acc_hi,
  input  logic [N-1:0] i_acc_lo,
  output logic [N:0]   o_acc_hi,
  output logic [N-1:0] o_acc_lo
);

  logic [N:0]   w_sum;
  logic [N:0]   w_rem_s;
  logic [N-1:0] w_quot_s;
  logic [N+1:0] w_diff;

  always_comb begin
    w_sum    = i_acc_lo[0] ? (i_acc_hi + {1'b0, i_a}) : i_acc_hi;
    w_rem_s  = {i_acc_hi[N-1:0], i_acc_lo[N-1]};
    w_quot_s = i_acc_lo << 1;
    // extra top bit of the difference acts as the borrow / sign
    w_diff   = {1'b0, w_rem_s} - {2'b00, i_b};
    o_acc_hi = {1'b0, w_sum[N:1]};
    o_acc_lo = {w_sum[0], i_acc_lo[N-1:1]};
    if (i_div) begin
      if (!w_diff[N+1]) begin
        o_acc_hi = w_diff[N:0];
        o_acc_lo = w_quot_s | N'(1);
      end else begin
        o_acc_hi = w_rem_s;
        o_acc_lo = w_quot_s;
      end
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative MULT/DIV engine, one bit per cycle, start/done handshake feeding the HI/LO stage.
// Optional macro MULDIV_ITER_EARLY_EXIT_EN: MULT with a zero operand retires after one RUN cycle.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [3:0]   i_f,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_hi_res,
  output logic [N-1:0] o_lo_res,
  output logic         o_dbz
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  muldiv_state_t r_state;
  logic          r_div;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N:0]    r_acc_hi;
  logic [N-1:0]  r_acc_lo;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_skip_zero;
  logic [N:0]    w_acc_hi_nxt;
  logic [N-1:0]  w_acc_lo_nxt;

  assign w_accept = i_start && (r_state != RUN) && ((i_f == F_MULT) || (i_f == F_DIV));

`ifdef MULDIV_ITER_EARLY_EXIT_EN
  assign w_skip_zero = !r_div && ((r_a == '0) || (r_b == '0));
`else
  assign w_skip_zero = 1'b0;
`endif

  muldiv_iter_step #(.N(N)) u_step (
    .i_div    (r_div),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_acc_hi (r_acc_hi),
    .i_acc_lo (r_acc_lo),
    .o_acc_hi (w_acc_hi_nxt),
    .o_acc_lo (w_acc_lo_nxt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_div    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_hi_res <= '0;
      o_lo_res <= '0;
      o_dbz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          o_done <= 1'b0;
          if (w_accept) begin
            r_div    <= (i_f == F_DIV);
            r_a      <= i_a;
            r_b      <= i_b;
            r_acc_hi <= '0;
            // multiply shifts the multiplier out of acc_lo; divide shifts the dividend
            r_acc_lo <= (i_f == F_DIV) ? i_a : i_b;
            r_cnt    <= '0;
            o_dbz    <= 1'b0;
            o_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_state  <= IDLE;
          end
        end
        RUN: begin
          if (r_div && (r_b == '0)) begin
            o_dbz   <= 1'b1;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= DONE;
          end else if (w_skip_zero) begin
            o_hi_res <= '0;
            o_lo_res <= '0;
            o_done   <= 1'b1;
            o_busy   <= 1'b0;
            r_state  <= DONE;
          end else begin
            r_acc_hi <= w_acc_hi_nxt;
            r_acc_lo <= w_acc_lo_nxt;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == LAST_STEP) begin
              o_hi_res <= w_acc_hi_nxt[N-1:0];
              o_lo_res <= w_acc_lo_nxt;
              o_done   <= 1'b1;
              o_busy   <= 1'b0;
              r_state  <= DONE;
            end
          end
        end
        default: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
